wb_stage_reg_ahbq: RTL

- Parametrised Memory-to-Writeback pipeline register for the RV32 core.
- Adds stall/flush control and a valid bit to the M->W stage.
- Adds a tagged AHB load-return queue. Outstanding AHB reads record their destination register at issue time. Returned data is retired to the register file in order, with any number of cycles of bus latency.
- Sits between the Memory stage, the AHB master interface and the register-file write port.

---
 rtl/wb_ahbq_pkg.sv | 25 ++
 rtl/wb_tag_fifo.sv | 85 ++++++++
 rtl/wb_stage_reg_ahbq.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/wb_ahbq_pkg.sv
// rtl/wb_ahbq_pkg.sv - shared types and constants for the M->W register and AHB load-return queue.
package wb_ahbq_pkg;

  localparam int XLEN_P = 32;
  localparam int RAW_P  = 5;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_e;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    result_src_e       result_src;
    logic [XLEN_P-1:0] alu_result;
    logic [XLEN_P-1:0] read_data;
    logic [RAW_P-1:0]  rd;
    logic [XLEN_P-1:0] pc_plus4;
  } wb_fields_t;

  localparam logic [RAW_P-1:0] REG_ZERO = '0;

endpackage

// File: rtl/wb_tag_fifo.sv
// rtl/wb_tag_fifo.sv - circular tag FIFO with count; WB_AHB_HAZARD_EN adds live-entry tag compare.
module wb_tag_fifo
  import wb_ahbq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             pop_ok_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o
`ifdef WB_AHB_HAZARD_EN
  ,
  input  logic [WIDTH-1:0] cmp_a_i,
  input  logic [WIDTH-1:0] cmp_b_i,
  output logic             match_o
`endif
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             pop_ok, push_ok;

  assign full_o   = (count_q == CW'(DEPTH));
  assign pop_ok   = pop_i && (count_q != '0);
  // A push into a full queue only lands when the head leaves in the same cycle.
  assign push_ok  = push_i && (!full_o || pop_ok);
  assign data_o   = mem_q[rd_ptr_q];
  assign pop_ok_o = pop_ok;
  assign count_o  = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok) count_d = count_q + 1'b1;
    else if (!push_ok && pop_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef WB_AHB_HAZARD_EN
  logic [AW-1:0] off;
  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    match_o = 1'b0;
    off     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr_q;
      if (({1'b0, off} < count_q) &&
          (((cmp_a_i != WIDTH'(REG_ZERO)) && (mem_q[i] == cmp_a_i)) ||
           ((cmp_b_i != WIDTH'(REG_ZERO)) && (mem_q[i] == cmp_b_i))))
        match_o = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/wb_stage_reg_ahbq.sv
// rtl/wb_stage_reg_ahbq.sv - M->W pipeline register with in-order AHB load-return queue.
// WB_AHB_HAZARD_EN adds rs1_d_i/rs2_d_i and ahb_hazard_o.
module wb_stage_reg_ahbq
  import wb_ahbq_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int RAW        = 5,
  parameter int AHB_QDEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          stall_i,
  input  logic                          flush_i,
  input  logic                          valid_m_i,
  input  logic                          reg_write_m_i,
  input  logic [1:0]                    result_src_m_i,
  input  logic [XLEN-1:0]               alu_result_m_i,
  input  logic [XLEN-1:0]               read_data_m_i,
  input  logic [RAW-1:0]                rd_m_i,
  input  logic [XLEN-1:0]               pc_plus4_m_i,
  output logic                          valid_w_o,
  output logic                          reg_write_w_o,
  output logic [1:0]                    result_src_w_o,
  output logic [XLEN-1:0]               alu_result_w_o,
  output logic [XLEN-1:0]               read_data_w_o,
  output logic [RAW-1:0]                rd_w_o,
  output logic [XLEN-1:0]               pc_plus4_w_o,
  input  logic                          ahb_req_i,
  input  logic                          ahb_rvalid_i,
  input  logic [XLEN-1:0]               ahb_rdata_i,
  output logic                          ahb_we_o,
  output logic [RAW-1:0]                ahb_wa_o,
  output logic [XLEN-1:0]               ahb_wd_o,
  output logic                          ahb_full_stall_o,
  output logic [$clog2(AHB_QDEPTH):0]   ahb_pending_o,
  output logic                          ahb_underflow_o
`ifdef WB_AHB_HAZARD_EN
  ,
  input  logic [RAW-1:0]                rs1_d_i,
  input  logic [RAW-1:0]                rs2_d_i,
  output logic                          ahb_hazard_o
`endif
);

  logic            valid_q, valid_d, reg_write_q, reg_write_d;
  logic [1:0]      result_src_q, result_src_d;
  logic [XLEN-1:0] alu_result_q, alu_result_d, read_data_q, read_data_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic [RAW-1:0]  rd_q, rd_d;
  logic            ahb_we_q, ahb_we_d, underflow_q, underflow_d;
  logic [RAW-1:0]  ahb_wa_q, ahb_wa_d, head_tag;
  logic [XLEN-1:0] ahb_wd_q, ahb_wd_d;
  logic            push, pop_ok, q_full;

  assign push = ahb_req_i && valid_m_i && !flush_i && !stall_i;

  wb_tag_fifo #(.DEPTH(AHB_QDEPTH), .WIDTH(RAW)) u_tag_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_i   (push),
    .pop_i    (ahb_rvalid_i),
    .data_i   (rd_m_i),
    .data_o   (head_tag),
    .pop_ok_o (pop_ok),
    .count_o  (ahb_pending_o),
    .full_o   (q_full)
`ifdef WB_AHB_HAZARD_EN
    ,
    .cmp_a_i  (rs1_d_i),
    .cmp_b_i  (rs2_d_i),
    .match_o  (ahb_hazard_o)
`endif
  );

  assign ahb_full_stall_o = q_full && ahb_req_i && !ahb_rvalid_i;

  always_comb begin
    valid_d      = valid_m_i;
    reg_write_d  = reg_write_m_i && valid_m_i;
    result_src_d = result_src_m_i;
    alu_result_d = alu_result_m_i;
    read_data_d  = read_data_m_i;
    rd_d         = rd_m_i;
    pc_plus4_d   = pc_plus4_m_i;
    if (flush_i) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end else if (stall_i) begin
      valid_d      = valid_q;
      reg_write_d  = reg_write_q;
      result_src_d = result_src_q;
      alu_result_d = alu_result_q;
      read_data_d  = read_data_q;
      rd_d         = rd_q;
      pc_plus4_d   = pc_plus4_q;
    end
  end

  // Retire is independent of stall/flush: the bus read already happened.
  always_comb begin
    ahb_we_d    = pop_ok && (head_tag != RAW'(REG_ZERO));
    ahb_wa_d    = pop_ok ? head_tag : ahb_wa_q;
    ahb_wd_d    = pop_ok ? ahb_rdata_i : ahb_wd_q;
    underflow_d = underflow_q || (ahb_rvalid_i && !pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      result_src_q <= RES_ALU;
      alu_result_q <= '0;
      read_data_q  <= '0;
      rd_q         <= '0;
      pc_plus4_q   <= '0;
      ahb_we_q     <= 1'b0;
      ahb_wa_q     <= '0;
      ahb_wd_q     <= '0;
      underflow_q  <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      result_src_q <= result_src_d;
      alu_result_q <= alu_result_d;
      read_data_q  <= read_data_d;
      rd_q         <= rd_d;
      pc_plus4_q   <= pc_plus4_d;
      ahb_we_q     <= ahb_we_d;
      ahb_wa_q     <= ahb_wa_d;
      ahb_wd_q     <= ahb_wd_d;
      underflow_q  <= underflow_d;
    end
  end

  assign valid_w_o       = valid_q;
  assign reg_write_w_o   = reg_write_q;
  assign result_src_w_o  = result_src_q;
  assign alu_result_w_o  = alu_result_q;
  assign read_data_w_o   = read_data_q;
  assign rd_w_o          = rd_q;
  assign pc_plus4_w_o    = pc_plus4_q;
  assign ahb_we_o        = ahb_we_q;
  assign ahb_wa_o        = ahb_wa_q;
  assign ahb_wd_o        = ahb_wd_q;
  assign ahb_underflow_o = underflow_q;

endmodule
